// File: rtl/gpio_memif_arb_if.sv
// scarv_ccx_memif: single-cycle request/grant memory port shared by the CCX
// masters and peripherals. REQ is the master side, RSP the slave side.
interface scarv_ccx_memif;
    logic        req;
    logic        gnt;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        error;

    modport REQ (output req, output wen, output addr, output wdata,
                 input  gnt, input  rdata, input  error);
    modport RSP (input  req, input  wen, input  addr, input  wdata,
                 output gnt, output rdata, output error);
endinterface

// File: rtl/gpio_memif_arb.sv
// gpio_memif_arb: two-master arbiter in front of one peripheral memif port.
// Combinational routing, stall lock, burst-limited round-robin priority.
// Optional accept counters are built when SCARV_SOC_GPIO_ARB_PERF_EN is defined.
module gpio_memif_arb #(
    parameter int unsigned MAX_BURST = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic        g_clk_req,
    scarv_ccx_memif.RSP memif_a,
    scarv_ccx_memif.RSP memif_b,
    scarv_ccx_memif.REQ memif_p
`ifdef SCARV_SOC_GPIO_ARB_PERF_EN
    ,
    output logic [31:0] perf_a_count,
    output logic [31:0] perf_b_count
`endif
);
    localparam int unsigned   BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic { ID_A = 1'b0, ID_B = 1'b1 } id_t;

    logic          lock_valid_q, lock_valid_d;
    id_t           lock_id_q, lock_id_d;
    id_t           last_id_q, last_id_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    id_t           win_id;
    logic          win_vld;
    logic          sel_a, sel_b, p_req, accept;

    // Pick this cycle's owner: a stalled owner first, then burst-limited round robin.
    always_comb begin
        win_vld = 1'b0;
        win_id  = ID_A;
        if (lock_valid_q) begin
            win_vld = 1'b1;
            win_id  = lock_id_q;
        end else if (memif_a.req && memif_b.req) begin
            win_vld = 1'b1;
            if (burst_cnt_q < BURST_MAX) win_id = last_id_q;
            else                         win_id = (last_id_q == ID_A) ? ID_B : ID_A;
        end else if (memif_a.req) begin
            win_vld = 1'b1;
            win_id  = ID_A;
        end else if (memif_b.req) begin
            win_vld = 1'b1;
            win_id  = ID_B;
        end
    end

    // Everything is gated by reset so outputs are quiet the moment reset asserts.
    assign sel_a  = g_resetn && win_vld && (win_id == ID_A);
    assign sel_b  = g_resetn && win_vld && (win_id == ID_B);
    // A locked owner that drops req produces no peripheral request.
    assign p_req  = (sel_a && memif_a.req) || (sel_b && memif_b.req);
    assign accept = p_req && memif_p.gnt;

    assign memif_p.req   = p_req;
    assign memif_p.wen   = (sel_a && memif_a.wen) || (sel_b && memif_b.wen);
    assign memif_p.addr  = sel_a ? memif_a.addr  : (sel_b ? memif_b.addr  : 32'h0);
    assign memif_p.wdata = sel_a ? memif_a.wdata : (sel_b ? memif_b.wdata : 32'h0);

    assign memif_a.gnt   = sel_a && accept;
    assign memif_b.gnt   = sel_b && accept;
    assign memif_a.rdata = sel_a ? memif_p.rdata : 32'h0;
    assign memif_b.rdata = sel_b ? memif_p.rdata : 32'h0;
    assign memif_a.error = sel_a && memif_p.error;
    assign memif_b.error = sel_b && memif_p.error;

    assign g_clk_req = g_resetn && (memif_a.req || memif_b.req || lock_valid_q);

    // Next arbitration state: lock follows the stall, burst counts accepts by the same owner.
    always_comb begin
        lock_valid_d = p_req && !memif_p.gnt;
        lock_id_d    = win_id;
        last_id_d    = last_id_q;
        burst_cnt_d  = burst_cnt_q;
        if (accept) begin
            last_id_d = win_id;
            if (win_id == last_id_q)
                burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
            else
                burst_cnt_d = BW'(1);
        end
    end

    // Arbitration state registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= ID_A;
            last_id_q    <= ID_A;
            burst_cnt_q  <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            last_id_q    <= last_id_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

`ifdef SCARV_SOC_GPIO_ARB_PERF_EN
    logic [31:0] perf_a_q, perf_a_d, perf_b_q, perf_b_d;

    // Free-running accept counters, wrapping naturally at 32 bits.
    always_comb begin
        perf_a_d = perf_a_q;
        perf_b_d = perf_b_q;
        if (accept && win_id == ID_A) perf_a_d = perf_a_q + 32'd1;
        if (accept && win_id == ID_B) perf_b_d = perf_b_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            perf_a_q <= 32'h0;
            perf_b_q <= 32'h0;
        end else begin
            perf_a_q <= perf_a_d;
            perf_b_q <= perf_b_d;
        end
    end

    assign perf_a_count = perf_a_q;
    assign perf_b_count = perf_b_q;
`endif

endmodule
